// File: rtl/prog_timer.sv
// Programmable down-counting interval timer: prescaled count-down from a latched
// interval, one-shot or auto-reload, with a one-cycle terminal tick and a sticky irq.
module prog_timer #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  mode,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  irq_clr,
    output logic [WIDTH-1:0]      count,
    output logic                  running,
    output logic                  tick,
    output logic                  irq
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0]      l_q, l_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic                  mode_q, mode_d;
    logic                  tick_q, tick_d;
    logic                  irq_q, irq_d;
    logic                  terminal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            pre_q   <= '0;
            l_q     <= '0;
            p_q     <= '0;
            mode_q  <= 1'b0;
            tick_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            l_q     <= l_d;
            p_q     <= p_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        pre_d    = pre_q;
        l_d      = l_q;
        p_d      = p_q;
        mode_d   = mode_q;
        terminal = 1'b0;

        // stop wins over start; a (re)start discards whatever event this edge held
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = RUN;
            count_d = load_val;
            pre_d   = '0;
            l_d     = load_val;
            p_d     = prescale;
            mode_d  = mode;
        end else if (state_q == RUN) begin
            if (pre_q == p_q) begin
                pre_d = '0;
                if (count_q != '0) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    terminal = 1'b1;
                    if (mode_q) begin
                        count_d = l_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end else begin
                pre_d = pre_q + PRE_ONE;
            end
        end

        tick_d = terminal;

        // a terminal event must never be lost to a simultaneous clear
        if (terminal) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    assign count   = count_q;
    assign running = (state_q == RUN);
    assign tick    = tick_q;
    assign irq     = irq_q;

endmodule
